apu_mixer: RTL and testbench



---
 rtl/apu_pkg.sv | 19 +
 rtl/apu_mix_scaler.sv | 54 +++++
 rtl/apu_mixer.sv | 139 +++++++++++++
 tb/tb_apu_mixer.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/apu_pkg.sv
// apu_mixer shared types, constants and helpers.
// State enum, centre level and accumulator sizing.
package apu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    SCALE,
    OUT
  } mix_state_e;

  localparam int LEVEL_MID = 15;

  // Sign + 5-bit centred value + one bit of growth per channel doubling.
  function automatic int acc_width(input int n);
    return 6 + $clog2(n);
  endfunction

endpackage

// File: rtl/apu_mix_scaler.sv
// apu_mixer volume scaler: acc * (vol+1) <<< OUT_SHIFT, reduced to OUT_W.
// Clamps when APU_MIXER_SATURATE_EN is defined, otherwise wraps.
module apu_mix_scaler #(
  parameter int ACC_W     = 8,
  parameter int OUT_W     = 16,
  parameter int OUT_SHIFT = 6
) (
  input  logic signed [ACC_W-1:0] acc,
  input  logic [2:0]              vol,
  input  logic                    en,
  output logic [OUT_W-1:0]        sample
);

  localparam int RAW_W  = ACC_W + 4 + OUT_SHIFT;
  localparam int FULL_W = (RAW_W > OUT_W) ? RAW_W : OUT_W + 1;

  logic signed [FULL_W-1:0] acc_x;
  logic signed [FULL_W-1:0] gain_x;
  logic signed [FULL_W-1:0] full;
  logic [FULL_W-OUT_W:0]    hi;
  logic                     fits;

  assign acc_x  = {{(FULL_W-ACC_W){acc[ACC_W-1]}}, acc};
  assign gain_x = FULL_W'({1'b0, vol}) + FULL_W'(1);
  assign full   = (acc_x * gain_x) <<< OUT_SHIFT;
  assign hi     = full[FULL_W-1:OUT_W-1];
  assign fits   = (hi == '0) || (hi == '1);

`ifdef APU_MIXER_SATURATE_EN
  // Clamp out-of-range results to the signed OUT_W extremes.
  always_comb begin
    sample = '0;
    if (en) begin
      if (fits)
        sample = full[OUT_W-1:0];
      else if (full[FULL_W-1])
        sample = {1'b1, {(OUT_W-1){1'b0}}};
      else
        sample = {1'b0, {(OUT_W-1){1'b1}}};
    end
  end
`else
  logic unused_fits;
  assign unused_fits = fits;

  // Keep only the low OUT_W bits (two's-complement wrap).
  always_comb begin
    sample = '0;
    if (en)
      sample = full[OUT_W-1:0];
  end
`endif

endmodule

// File: rtl/apu_mixer.sv
// apu_mixer: serial stereo mixer, one channel per clock, ac97_bitclk domain.
// Saturation of the scaled result is enabled by APU_MIXER_SATURATE_EN.
module apu_mixer
  import apu_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int LEVEL_W   = 4,
  parameter int OUT_W     = 16,
  parameter int OUT_SHIFT = 6
) (
  input  logic                      ac97_bitclk,
  input  logic                      reset_b,
  input  logic [NUM_CH*LEVEL_W-1:0] ch_level,
  input  logic [NUM_CH-1:0]         so1_ch_enable,
  input  logic [NUM_CH-1:0]         so2_ch_enable,
  input  logic [2:0]                so1_output_level,
  input  logic [2:0]                so2_output_level,
  input  logic                      master_sound_enable,
  input  logic                      sample_req,
  output logic [OUT_W-1:0]          right_sample,
  output logic [OUT_W-1:0]          left_sample,
  output logic                      sample_valid,
  output logic                      busy,
  output logic                      overrun
);

  localparam int ACC_W = acc_width(NUM_CH);
  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_CH - 1);

  mix_state_e state_q, state_d;

  logic [NUM_CH*LEVEL_W-1:0] lvl_q;
  logic [NUM_CH-1:0]         so1_q;
  logic [NUM_CH-1:0]         so2_q;
  logic [2:0]                vol1_q;
  logic [2:0]                vol2_q;
  logic                      master_q;
  logic [IDX_W-1:0]          idx_q;
  logic signed [ACC_W-1:0]   acc1_q;
  logic signed [ACC_W-1:0]   acc2_q;
  logic signed [ACC_W-1:0]   centred;
  logic [LEVEL_W-1:0]        level;
  logic [OUT_W-1:0]          scaled1;
  logic [OUT_W-1:0]          scaled2;
  logic                      accept;

  assign accept  = (state_q == IDLE) && sample_req;
  assign busy    = (state_q != IDLE);
  assign level   = lvl_q[int'(idx_q)*LEVEL_W +: LEVEL_W];
  assign centred = ACC_W'({1'b0, level, 1'b0}) - ACC_W'(LEVEL_MID);

  // State register.
  always_ff @(posedge ac97_bitclk) begin
    if (!reset_b)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  // Next-state: accept, walk the channels, scale, present.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (sample_req) state_d = ACCUM;
      ACCUM:   if (idx_q == IDX_LAST) state_d = SCALE;
      SCALE:   state_d = OUT;
      OUT:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Snapshot, accumulate, register outputs, track overrun.
  always_ff @(posedge ac97_bitclk) begin
    if (!reset_b) begin
      lvl_q        <= '0;
      so1_q        <= '0;
      so2_q        <= '0;
      vol1_q       <= '0;
      vol2_q       <= '0;
      master_q     <= 1'b0;
      idx_q        <= '0;
      acc1_q       <= '0;
      acc2_q       <= '0;
      right_sample <= '0;
      left_sample  <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      if (accept) begin
        lvl_q    <= ch_level;
        so1_q    <= so1_ch_enable;
        so2_q    <= so2_ch_enable;
        vol1_q   <= so1_output_level;
        vol2_q   <= so2_output_level;
        master_q <= master_sound_enable;
        idx_q    <= '0;
        acc1_q   <= '0;
        acc2_q   <= '0;
      end
      if (sample_req && state_q != IDLE)
        overrun <= 1'b1;
      if (state_q == ACCUM) begin
        if (so1_q[idx_q]) acc1_q <= acc1_q + centred;
        if (so2_q[idx_q]) acc2_q <= acc2_q + centred;
        idx_q <= idx_q + IDX_W'(1);
      end
      if (state_q == SCALE) begin
        right_sample <= scaled1;
        left_sample  <= scaled2;
        sample_valid <= 1'b1;
      end
    end
  end

  apu_mix_scaler #(
    .ACC_W     (ACC_W),
    .OUT_W     (OUT_W),
    .OUT_SHIFT (OUT_SHIFT)
  ) u_so1 (
    .acc    (acc1_q),
    .vol    (vol1_q),
    .en     (master_q),
    .sample (scaled1)
  );

  apu_mix_scaler #(
    .ACC_W     (ACC_W),
    .OUT_W     (OUT_W),
    .OUT_SHIFT (OUT_SHIFT)
  ) u_so2 (
    .acc    (acc2_q),
    .vol    (vol2_q),
    .en     (master_q),
    .sample (scaled2)
  );

endmodule

// File: tb/tb_apu_mixer.sv
// Directed self-checking bench for apu_mixer.
// Second instance with OUT_SHIFT=7 exercises the saturate/wrap path.
module tb_apu_mixer;

  logic        clk;
  logic        reset_b;
  logic [15:0] ch_level;
  logic [3:0]  so1_ch_enable;
  logic [3:0]  so2_ch_enable;
  logic [2:0]  so1_output_level;
  logic [2:0]  so2_output_level;
  logic        master_sound_enable;
  logic        sample_req;

  logic [15:0] right_sample, left_sample;
  logic        sample_valid, busy, overrun;
  logic [15:0] right7, left7;
  logic        valid7, busy7, overrun7;

  int nchk = 0;
  int nerr = 0;

`ifdef APU_MIXER_SATURATE_EN
  localparam int EXP7 = 32767;
`else
  localparam int EXP7 = -4096;
`endif

  apu_mixer #(.NUM_CH(4), .LEVEL_W(4), .OUT_W(16), .OUT_SHIFT(6)) dut (
    .ac97_bitclk         (clk),
    .reset_b             (reset_b),
    .ch_level            (ch_level),
    .so1_ch_enable       (so1_ch_enable),
    .so2_ch_enable       (so2_ch_enable),
    .so1_output_level    (so1_output_level),
    .so2_output_level    (so2_output_level),
    .master_sound_enable (master_sound_enable),
    .sample_req          (sample_req),
    .right_sample        (right_sample),
    .left_sample         (left_sample),
    .sample_valid        (sample_valid),
    .busy                (busy),
    .overrun             (overrun)
  );

  apu_mixer #(.NUM_CH(4), .LEVEL_W(4), .OUT_W(16), .OUT_SHIFT(7)) dut7 (
    .ac97_bitclk         (clk),
    .reset_b             (reset_b),
    .ch_level            (ch_level),
    .so1_ch_enable       (so1_ch_enable),
    .so2_ch_enable       (so2_ch_enable),
    .so1_output_level    (so1_output_level),
    .so2_output_level    (so2_output_level),
    .master_sound_enable (master_sound_enable),
    .sample_req          (sample_req),
    .right_sample        (right7),
    .left_sample         (left7),
    .sample_valid        (valid7),
    .busy                (busy7),
    .overrun             (overrun7)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    nchk++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_full(input logic master);
    ch_level            = 16'hFFFF;
    so1_ch_enable       = 4'b1111;
    so2_ch_enable       = 4'b1111;
    so1_output_level    = 3'd7;
    so2_output_level    = 3'd7;
    master_sound_enable = master;
  endtask

  // Request in cycle T, then observe cycles T+1..T+7; ends inside T+7.
  task automatic run(input int extra, input bit scramble,
                     output int fv, output int nv,
                     output int busy_bad, output logic [7:0] ovr);
    fv = -1;
    nv = 0;
    busy_bad = 0;
    ovr = '0;
    sample_req = 1'b1;
    tick();
    for (int c = 1; c <= 7; c++) begin
      if (scramble && c == 1) begin
        ch_level            = 16'h5A3C;
        so1_ch_enable       = 4'b1111;
        so2_ch_enable       = 4'b1111;
        so1_output_level    = 3'd3;
        so2_output_level    = 3'd5;
        master_sound_enable = 1'b1;
      end
      sample_req = (c == extra);
      #4;
      if (sample_valid === 1'b1) begin
        nv++;
        if (fv < 0) fv = c;
      end
      if (busy !== (c <= 6)) busy_bad++;
      ovr[c] = overrun;
      if (c < 7) tick();
    end
    sample_req = 1'b0;
  endtask

  int fv, nv, bb, seen;
  logic [7:0] ovr;

  initial begin
    reset_b             = 1'b0;
    ch_level            = '0;
    so1_ch_enable       = '0;
    so2_ch_enable       = '0;
    so1_output_level    = '0;
    so2_output_level    = '0;
    master_sound_enable = 1'b0;
    sample_req          = 1'b0;

    repeat (3) tick();
    reset_b = 1'b1;
    tick();
    check("rst_left", $signed(left_sample), 0);
    check("rst_right", $signed(right_sample), 0);
    check("rst_valid", sample_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (sample_valid !== 1'b0) seen++;
    end
    check("idle_no_valid", seen, 0);

    set_full(1'b1);
    run(-1, 1'b0, fv, nv, bb, ovr);
    check("full_valid_cycle", fv, 6);
    check("full_valid_count", nv, 1);
    check("full_busy", bb, 0);
    check("full_left", $signed(left_sample), 30720);
    check("full_right", $signed(right_sample), 30720);
    check("shift7_right", $signed(right7), EXP7);
    check("shift7_left", $signed(left7), EXP7);
    check("full_overrun", overrun, 0);

    ch_level            = 16'hFFF0;
    so1_ch_enable       = 4'b0001;
    so2_ch_enable       = 4'b0000;
    so1_output_level    = 3'd0;
    so2_output_level    = 3'd7;
    master_sound_enable = 1'b1;
    run(-1, 1'b1, fv, nv, bb, ovr);
    check("pan_valid_cycle", fv, 6);
    check("pan_right", $signed(right_sample), -960);
    check("pan_left", $signed(left_sample), 0);
    check("pan_right7", $signed(right7), -1920);
    check("b2b_no_overrun", overrun, 0);

    set_full(1'b0);
    run(-1, 1'b1, fv, nv, bb, ovr);
    check("mute_valid_cycle", fv, 6);
    check("mute_valid_count", nv, 1);
    check("mute_left", $signed(left_sample), 0);
    check("mute_right", $signed(right_sample), 0);

    set_full(1'b1);
    run(2, 1'b0, fv, nv, bb, ovr);
    check("ovr_valid_count", nv, 1);
    check("ovr_valid_cycle", fv, 6);
    check("ovr_timeline", ovr, 8'hF8);
    check("ovr_left", $signed(left_sample), 30720);
    repeat (5) tick();
    check("ovr_sticky", overrun, 1);

    sample_req = 1'b1;
    tick();
    sample_req = 1'b0;
    tick();
    tick();
    reset_b = 1'b0;
    tick();
    #4;
    check("abort_busy", busy, 0);
    check("abort_valid", sample_valid, 0);
    check("abort_left", $signed(left_sample), 0);
    check("abort_right", $signed(right_sample), 0);
    check("abort_overrun", overrun, 0);
    reset_b = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (sample_valid !== 1'b0) seen++;
    end
    check("abort_no_valid", seen, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
    $finish;
  end

endmodule
